// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: reset address, next-PC
// op codes, and the IF/ID pipeline register layout.
package if_fetch_pkg;

    localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        err;
    } ifid_t;

    // Branch displacement in bytes: sign-extended word offset, shifted left by 2.
    function automatic logic [31:0] br_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: ROM address/data plus the D-stage redirect and stall controls.
// master = pipeline/ROM side, slave = fetch stage.
interface if_fetch_if;
    logic        stall;
    logic [1:0]  D_npc_op;
    logic        D_br_taken;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_val;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_fetch_err;

    modport master (
        output stall, D_npc_op, D_br_taken, D_imm26, D_rs_val, F_instr,
        input  F_pc, D_pc, D_instr, D_valid, D_fetch_err
    );

    modport slave (
        input  stall, D_npc_op, D_br_taken, D_imm26, D_rs_val, F_instr,
        output F_pc, D_pc, D_instr, D_valid, D_fetch_err
    );
endinterface

// File: rtl/if_fetch_npc_calc.sv
// Combinational next-PC selection. Redirects are computed from the D-stage PC,
// so the instruction currently in F always executes as the delay slot.
module npc_calc
    import if_fetch_pkg::*;
(
    input  logic [31:0] f_pc_i,
    input  logic [31:0] d_pc_i,
    input  logic [1:0]  npc_op_i,
    input  logic        br_taken_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] rs_val_i,
    output logic [31:0] npc_o
);

    always_comb begin
        npc_o = f_pc_i + 32'd4;
        case (npc_op_i)
            NPC_BR:  if (br_taken_i) npc_o = d_pc_i + 32'd4 + br_offset(imm26_i[15:0]);
            NPC_J:   npc_o = {d_pc_i[31:28], imm26_i, 2'b00};
            NPC_JR:  npc_o = rs_val_i;
            default: npc_o = f_pc_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, fetch-window/alignment check, and the
// IF/ID pipeline register. Stall freezes both registers together.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] INIT_PC  = INITIAL_ADDRESS,
    parameter int          IM_WORDS = 4096
) (
    input  logic       clk,
    input  logic       reset,
    if_fetch_if.slave  bus
);

    localparam logic [31:0] PC_END = INIT_PC + 32'(4 * IM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic [31:0] npc;
    logic        fetch_err;
    ifid_t       ifid_q, ifid_d;

    assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < INIT_PC) || (pc_q >= PC_END);

    npc_calc u_npc_calc (
        .f_pc_i     (pc_q),
        .d_pc_i     (ifid_q.pc),
        .npc_op_i   (bus.D_npc_op),
        .br_taken_i (bus.D_br_taken),
        .imm26_i    (bus.D_imm26),
        .rs_val_i   (bus.D_rs_val),
        .npc_o      (npc)
    );

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (!bus.stall) begin
            pc_d         = npc;
            ifid_d.pc    = pc_q;
            // Faulting fetches become nops but keep their PC for the exception path.
            ifid_d.instr = fetch_err ? NOP_INSTR : bus.F_instr;
            ifid_d.valid = 1'b1;
            ifid_d.err   = fetch_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= INIT_PC;
            ifid_q <= '{pc: INIT_PC, instr: NOP_INSTR, valid: 1'b0, err: 1'b0};
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign bus.F_pc        = pc_q;
    assign bus.D_pc        = ifid_q.pc;
    assign bus.D_instr     = ifid_q.instr;
    assign bus.D_valid     = ifid_q.valid;
    assign bus.D_fetch_err = ifid_q.err;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a behavioural ROM, a hand-written sequential/
// ROM-corruption sequence, and a table of per-edge vectors with expected outputs.
module tb_if_fetch;
    logic clk;
    logic reset;
    if_fetch_if bus();

    if_fetch #(.INIT_PC(32'h0000_3000), .IM_WORDS(4096)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rom [0:4095];
    logic [31:0] rom_rd;
    always_comb begin
        rom_rd = 32'hBAD0_BAD0;
        if (bus.F_pc >= 32'h0000_3000 && bus.F_pc < 32'h0000_7000)
            rom_rd = rom[12'((bus.F_pc - 32'h0000_3000) >> 2)];
    end
    assign bus.F_instr = rom_rd;

    // Expected ROM contents for an aligned in-window address.
    function automatic logic [31:0] w(input logic [31:0] pc);
        logic [31:0] idx;
        idx = (pc - 32'h0000_3000) >> 2;
        if (pc == 32'h0000_3000) return 32'h2401_0001;
        return 32'hA000_0000 | idx;
    endfunction

    typedef struct {
        bit          rst;
        bit          stall;
        logic [1:0]  op;
        bit          tk;
        logic [25:0] imm;
        logic [31:0] rs;
        logic [31:0] f;
        logic [31:0] dpc;
        logic [31:0] di;
        bit          v;
        bit          e;
    } vec_t;

    vec_t vt[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic add(input bit rst, input bit st, input logic [1:0] op, input bit tk,
                       input logic [25:0] imm, input logic [31:0] rs, input logic [31:0] f,
                       input logic [31:0] dpc, input logic [31:0] di, input bit v, input bit e);
        vec_t r;
        r = '{rst: rst, stall: st, op: op, tk: tk, imm: imm, rs: rs,
              f: f, dpc: dpc, di: di, v: v, e: e};
        vt.push_back(r);
    endtask

    task automatic add_rst(input bit st);
        add(1, st, 2'd0, 0, 26'd0, 32'd0, 32'h3000, 32'h3000, 32'h0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input vec_t r);
        chk({tag, " F_pc"},        bus.F_pc,                r.f);
        chk({tag, " D_pc"},        bus.D_pc,                r.dpc);
        chk({tag, " D_instr"},     bus.D_instr,             r.di);
        chk({tag, " D_valid"},     {31'd0, bus.D_valid},     {31'd0, r.v});
        chk({tag, " D_fetch_err"}, {31'd0, bus.D_fetch_err}, {31'd0, r.e});
    endtask

    task automatic drive_seq();
        bus.stall = 0; bus.D_npc_op = 2'd0; bus.D_br_taken = 0;
        bus.D_imm26 = 26'd0; bus.D_rs_val = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'hA000_0000 | 32'(i);
        rom[0] = 32'h2401_0001;
        reset = 1'b0;
        drive_seq();

        // Sequential fetch from reset, then corrupt the word about to be fetched.
        @(negedge clk); #2;
        chk("rst F_pc", bus.F_pc, 32'h3000);
        chk("rst D_valid", {31'd0, bus.D_valid}, 32'd0);
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("seq%0d D_pc", k), bus.D_pc, 32'h3000 + 32'(4 * k));
            @(negedge clk);
        end
        chk("seq F_pc", bus.F_pc, 32'h3020);
        rom[8] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("corrupt D_instr", bus.D_instr, 32'hDEAD_BEEF);
        chk("corrupt D_pc", bus.D_pc, 32'h3020);
        rom[8] = 32'hA000_0008;

        // Taken branch at 0x3008, imm 3.
        add_rst(0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3004,32'h3000,w(32'h3000),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3008,32'h3004,w(32'h3004),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h300C,32'h3008,w(32'h3008),1,0);
        add(0,0,2'd1,1,26'h3,32'h0, 32'h3018,32'h300C,w(32'h300C),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h301C,32'h3018,w(32'h3018),1,0);
        // Not-taken branch, j, jr, stall with pending jump, misaligned jr.
        add_rst(0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3004,32'h3000,w(32'h3000),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3008,32'h3004,w(32'h3004),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h300C,32'h3008,w(32'h3008),1,0);
        add(0,0,2'd1,0,26'h3,32'h0, 32'h3010,32'h300C,w(32'h300C),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3014,32'h3010,w(32'h3010),1,0);
        add(0,0,2'd2,0,26'hC10,32'h0, 32'h3040,32'h3014,w(32'h3014),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3044,32'h3040,w(32'h3040),1,0);
        add(0,0,2'd3,0,26'h0,32'h3100, 32'h3100,32'h3044,w(32'h3044),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3104,32'h3100,w(32'h3100),1,0);
        for (int s = 0; s < 3; s++)
            add(0,1,2'd2,0,26'hC20,32'h0, 32'h3104,32'h3100,w(32'h3100),1,0);
        add(0,0,2'd2,0,26'hC20,32'h0, 32'h3080,32'h3104,w(32'h3104),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3084,32'h3080,w(32'h3080),1,0);
        add(0,0,2'd3,0,26'h0,32'h3102, 32'h3102,32'h3084,w(32'h3084),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3106,32'h3102,32'h0,1,1);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h310A,32'h3106,32'h0,1,1);
        // jr to the first address past the window, then reset during a stall.
        add_rst(0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3004,32'h3000,w(32'h3000),1,0);
        add(0,0,2'd3,0,26'h0,32'h7000, 32'h7000,32'h3004,w(32'h3004),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h7004,32'h7000,32'h0,1,1);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h7008,32'h7004,32'h0,1,1);
        add(0,1,2'd2,0,26'hC20,32'h0, 32'h7008,32'h7004,32'h0,1,1);
        add_rst(1);
        // Last in-window word and the word just below the window.
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3004,32'h3000,w(32'h3000),1,0);
        add(0,0,2'd3,0,26'h0,32'h6FFC, 32'h6FFC,32'h3004,w(32'h3004),1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h7000,32'h6FFC,32'hA000_0FFF,1,0);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h7004,32'h7000,32'h0,1,1);
        add(0,0,2'd3,0,26'h0,32'h2FFC, 32'h2FFC,32'h7004,32'h0,1,1);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3000,32'h2FFC,32'h0,1,1);
        add(0,0,2'd0,0,26'h0,32'h0, 32'h3004,32'h3000,w(32'h3000),1,0);

        foreach (vt[i]) begin
            @(negedge clk);
            bus.stall = vt[i].stall; bus.D_npc_op = vt[i].op; bus.D_br_taken = vt[i].tk;
            bus.D_imm26 = vt[i].imm; bus.D_rs_val = vt[i].rs;
            if (vt[i].rst) begin
                reset = 1'b0;
                #2;
                chk_all($sformatf("v%0d async", i), vt[i]);
                @(posedge clk); #1;
                chk_all($sformatf("v%0d held", i), vt[i]);
            end else begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk_all($sformatf("v%0d", i), vt[i]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage pipelined MIPS core. The block owns the program counter and drives the fetch address into the instruction ROM. It takes the returned word and registers it, with its PC, into the IF/ID pipeline register. It also computes the next PC from D-stage branch/jump decisions, using architectural delay-slot semantics, and honours hazard-unit stalls.

## Interface
Parameters:
- `INIT_PC`, `32'h0000_3000`: reset PC; equals the shared `INITIAL_ADDRESS`.
- `IM_WORDS`, 4096: ROM depth in words; valid fetch window is `[INIT_PC, INIT_PC + 4*IM_WORDS)`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `D_npc_op`  in  2  `0` seq, `1` branch, `2` j/jal, `3` jr/jalr.
- `D_br_taken`  in  1  branch condition, already evaluated in D.
- `D_imm26`  in  26  low 26 bits of the D instruction; `[15:0]` is the branch offset.
- `D_rs_val`  in  32  forwarded rs value for jr.
- `F_pc`  out  32  fetch address to the instruction ROM (combinational from PC register).
- `F_instr`  in  32  ROM data for `F_pc`, same cycle.
- `D_pc`  out  32  registered PC of the D-stage instruction.
- `D_instr`  out  32  registered D-stage instruction.
- `D_valid`  out  1  D holds a real fetched instruction.
- `D_fetch_err`  out  1  D instruction came from a misaligned or out-of-window PC.

## Operation
- The PC register updates every edge unless `stall=1`.
- Next-PC selection:
  - `D_npc_op=0`, or `1` with `D_br_taken=0`: `F_pc+4`.
  - `1` and taken: `D_pc + 4 + (sext(imm16) << 2)`.
  - `2`: `{D_pc[31:28], D_imm26, 2'b00}`.
  - `3`: `D_rs_val`.
- Delay slot: the instruction being fetched while D redirects always enters D. No flush exists.
- The IF/ID register loads `{F_pc, F_instr, 1, err}` every edge unless `stall=1`. Under stall, all of D holds unchanged.
- Fetch error: `err = F_pc[1:0]!=0 || F_pc < INIT_PC || F_pc >= INIT_PC+4*IM_WORDS`. On error, `D_instr` loads `32'h0` (nop), `D_fetch_err=1`, and `D_pc` holds the faulting PC. The PC keeps advancing per the normal next-PC rule.
- All arithmetic is 32-bit modulo. Wrap past `32'hFFFF_FFFC` is allowed and flagged by `err`.
- `D_npc_op` values are ignored while `stall=1`. The stalled D instruction re-presents them on the cycle it is released.

## Timing
- Reset, asynchronous assert: `F_pc=INIT_PC`, `D_pc=INIT_PC`, `D_instr=0`, `D_valid=0`, `D_fetch_err=0`.
- Reset deassert: the first edge after deassert loads the IF/ID register with the word at `INIT_PC` and moves the PC to `INIT_PC+4`.
- Latency:
  - ROM to D: 1 cycle.
  - Redirect: the target is in `F_pc` one edge after the D-stage branch, so exactly one delay-slot instruction executes.
- Stall and redirect in the same cycle: the stall wins, and nothing changes.
- Reset mid-stall or mid-redirect: reset wins immediately; the pending redirect is lost.
- `stall` is sampled only at the edge. Multi-cycle stalls hold state for every stalled edge.

## Structure
- Shared constants package/header:
  - `INITIAL_ADDRESS`.
  - NPC op codes `NPC_SEQ/NPC_BR/NPC_J/NPC_JR`.
  - `NOP_INSTR`.
- One sub-module, `npc_calc`: purely combinational next-PC selection. The parent holds the PC register, the IF/ID register, and the fetch-error check.
- The instruction ROM stays a separate instance, wired via `F_pc`/`F_instr`.

## Test plan
- **Reset:** hold `reset=0` mid-run, then release; ROM has `0x3000:24010001`.
  - During reset: `F_pc=0x3000`, `D_valid=0`.
  - After the first edge: `D_pc=0x3000`, `D_instr=24010001`, `F_pc=0x3004`.
- **Sequential fetch:** 8 edges with no stall, then the ROM is corrupted.
  - During the 8 edges: `D_pc` steps `0x3000..0x301C`.
  - After corruption: the ROM word appears in D one edge later.
- **Taken branch:** D `beq` at `0x3008` with imm `0x0003`, taken.
  - Delay slot `0x300C` enters D.
  - Next `F_pc=0x3018`.
- **Not-taken branch:** same `beq` with `D_br_taken=0`.
  - `F_pc` continues to `0x3010`.
- **j and jr:**
  - `j` with `imm26=0x0000C10`: `F_pc=0x0000_3040`.
  - `jr` with `D_rs_val=0x3100`: `F_pc=0x3100`.
  - Both after exactly one delay slot.
- **Stall plus redirect, and errors:**
  - 3-cycle stall with `D_npc_op=2` asserted: PC and D frozen all 3 cycles; jump taken on the release edge.
  - `jr` to `0x3102`: `D_fetch_err=1`, `D_instr=0`.
  - `jr` to `0x7000`: `D_fetch_err=1`, `D_instr=0`.
